// File: rtl/nn_layer_mac.sv
// nn_layer_mac
// Fully-connected layer engine. Takes the loader's 64 unsigned 8-bit pixels
// and 1024 signed 16-bit weights and computes 16 neuron outputs, each a
// 64-term dot product. Each result is arithmetically shifted right by SHIFT,
// passed through ReLU (saturate to 0..255) or a signed clamp (-128..127),
// and stored as one byte of the result register.
//
// Ports:
//   clk         system clock, rising edge
//   nrst        asynchronous active-low reset
//   start       request a layer computation (only honoured while idle)
//   relu_en     activation select, captured with an accepted start
//   image_data  64 x 8-bit unsigned pixels, held stable while busy
//   coeff_data  1024 x 16-bit signed weights, [n*64+i] = input i -> neuron n
//   busy        high while accumulating or writing a neuron result
//   done        one-cycle pulse once all 16 result bytes are final
//   result      16 x 8-bit activated neuron outputs
module nn_layer_mac #(
   parameter int LANES = 4,
   parameter int SHIFT = 8
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 start,
   input  logic                 relu_en,
   input  logic [63:0][7:0]     image_data,
   input  logic [1023:0][15:0]  coeff_data,
   output logic                 busy,
   output logic                 done,
   output logic [15:0][7:0]     result
);

   localparam int CHUNKS = 64 / LANES;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] LAST_CHUNK = CW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MAC   = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state;
   state_t             next_state;
   logic signed [31:0] acc;
   logic [3:0]         n_cnt;
   logic [CW-1:0]      c_cnt;
   logic               relu_q;

   logic signed [31:0] lane_sum;
   logic [5:0]         pix_idx;
   logic [9:0]         coef_idx;
   logic signed [24:0] px_ext;
   logic signed [24:0] cf_ext;
   logic signed [24:0] prod;
   logic signed [31:0] shifted;
   logic [7:0]         act_byte;

   // Sum of LANES products for the current neuron/chunk. Pixels are
   // zero-extended and weights sign-extended to 25 bits; the true product
   // always fits in 25 signed bits, so the truncating multiply is exact.
   always_comb begin
      lane_sum = '0;
      pix_idx  = '0;
      coef_idx = '0;
      px_ext   = '0;
      cf_ext   = '0;
      prod     = '0;
      for (int k = 0; k < LANES; k++) begin
         pix_idx  = 6'(int'(c_cnt) * LANES + k);
         coef_idx = {n_cnt, pix_idx};
         px_ext   = {17'b0, image_data[pix_idx]};
         cf_ext   = {{9{coeff_data[coef_idx][15]}}, coeff_data[coef_idx]};
         prod     = px_ext * cf_ext;
         lane_sum = lane_sum + {{7{prod[24]}}, prod};
      end
   end

   // Shift (floor) then activate: ReLU saturates to 0..255, otherwise the
   // value is clamped to the signed byte range and stored two's-complement.
   always_comb begin
      shifted  = acc >>> SHIFT;
      act_byte = shifted[7:0];
      if (relu_q) begin
         if (shifted < 32'sd0)
            act_byte = 8'h00;
         else if (shifted > 32'sd255)
            act_byte = 8'hFF;
      end else begin
         if (shifted < -32'sd128)
            act_byte = 8'h80;
         else if (shifted > 32'sd127)
            act_byte = 8'h7F;
      end
   end

   // Next-state logic. start is only looked at in IDLE, so a request during
   // a run (including the DONE cycle) is simply dropped.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = MAC;
         MAC:     if (c_cnt == LAST_CHUNK) next_state = WRITE;
         WRITE:   next_state = (n_cnt == 4'd15) ? DONE : MAC;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Datapath registers. The result register is only touched one byte per
   // WRITE cycle, so old bytes persist until overwritten by a new run.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         acc    <= '0;
         n_cnt  <= '0;
         c_cnt  <= '0;
         relu_q <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc    <= '0;
                  n_cnt  <= '0;
                  c_cnt  <= '0;
                  relu_q <= relu_en;
               end
            end
            MAC: begin
               acc <= acc + lane_sum;
               if (c_cnt != LAST_CHUNK)
                  c_cnt <= c_cnt + CW'(1);
            end
            WRITE: begin
               result[n_cnt] <= act_byte;
               acc           <= '0;
               c_cnt         <= '0;
               if (n_cnt != 4'd15)
                  n_cnt <= n_cnt + 4'd1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state == MAC) || (state == WRITE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_nn_layer_mac.sv
// tb_nn_layer_mac
// Self-checking bench for nn_layer_mac (LANES=4, SHIFT=8). Directed table of
// uniform/diagonal patterns with known results, control-hazard sequences
// (late start pulses, mid-run reset) and randomized runs compared against an
// arithmetic dot-product reference model.
module tb_nn_layer_mac;

   localparam int LANES     = 4;
   localparam int SHIFT     = 8;
   localparam int BUSY_LEN  = 16 * (64 / LANES + 1);
   localparam int MAX_WAIT  = BUSY_LEN + 200;

   logic                clk;
   logic                nrst;
   logic                start;
   logic                relu_en;
   logic [63:0][7:0]    image_data;
   logic [1023:0][15:0] coeff_data;
   logic                busy;
   logic                done;
   logic [15:0][7:0]    result;

   int assert_cnt;
   int fail_cnt;

   nn_layer_mac #(.LANES(LANES), .SHIFT(SHIFT)) dut (
      .clk        (clk),
      .nrst       (nrst),
      .start      (start),
      .relu_en    (relu_en),
      .image_data (image_data),
      .coeff_data (coeff_data),
      .busy       (busy),
      .done       (done),
      .result     (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          kind;     // 0 = uniform fill, 1 = diagonal indexing
      logic [7:0]  pix;
      logic [15:0] coef;
      logic        relu;
      logic [7:0]  exp_byte; // every byte for uniform; ignored for diagonal
   } vec_t;

   // Generic comparison; every check in the bench goes through here.
   task automatic checkOutput(input string name, input logic [127:0] actual,
                              input logic [127:0] expected);
      assert_cnt++;
      if (actual !== expected) begin
         fail_cnt++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic loadPattern(input int kind, input logic [7:0] pix,
                              input logic [15:0] coef);
      for (int i = 0; i < 64; i++)
         image_data[i] = (kind == 1) ? 8'(i) : pix;
      for (int j = 0; j < 1024; j++) begin
         if (kind == 1)
            coeff_data[j] = ((j / 64) == (j % 64)) ? 16'd256 : 16'd0;
         else
            coeff_data[j] = coef;
      end
   endtask

   // Reference: plain 64-term dot product, floor shift, then activation.
   function automatic logic [7:0] refNeuron(input int n, input logic relu);
      longint acc;
      longint s;
      acc = 0;
      for (int i = 0; i < 64; i++)
         acc += longint'(image_data[i]) * longint'($signed(coeff_data[n*64+i]));
      s = acc >>> SHIFT;
      if (relu) begin
         if (s < 0) return 8'h00;
         if (s > 255) return 8'hFF;
         return 8'(s);
      end
      if (s < -128) return 8'h80;
      if (s > 127) return 8'h7F;
      return 8'(s);
   endfunction

   function automatic logic [127:0] refLayer(input logic relu);
      logic [15:0][7:0] r;
      for (int n = 0; n < 16; n++)
         r[n] = refNeuron(n, relu);
      return r;
   endfunction

   // Starts one run and observes it on falling edges. Cycle 1 is the first
   // falling edge after the rising edge that accepts start. Optionally pulses
   // start again during cycle pulse_at. Stops a few cycles after done or
   // when the wait bound runs out.
   task automatic applyStimulus(input logic relu, input int pulse_at,
                                output int busy_cnt, output int done_at,
                                output int done_cnt);
      @(negedge clk);
      relu_en = relu;
      start   = 1'b1;
      @(negedge clk);
      start    = 1'b0;
      busy_cnt = 0;
      done_at  = 0;
      done_cnt = 0;
      for (int cyc = 1; cyc <= MAX_WAIT; cyc++) begin
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++;
            if (done_at == 0) done_at = cyc;
         end
         if (done_at != 0 && cyc >= done_at + 4) break;
         start = (cyc == pulse_at);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic runAndCheck(input string tag, input logic relu,
                              input int pulse_at, input logic [127:0] exp_res);
      int bc, da, dc;
      applyStimulus(relu, pulse_at, bc, da, dc);
      checkOutput({tag, " busy_cycles"}, 128'(bc), 128'(BUSY_LEN));
      checkOutput({tag, " done_cycle"}, 128'(da), 128'(BUSY_LEN + 1));
      checkOutput({tag, " done_count"}, 128'(dc), 128'(1));
      checkOutput({tag, " result"}, result, exp_res);
   endtask

   vec_t             vecs[6];
   logic [15:0][7:0] diag_exp;
   logic [15:0][7:0] exp_v;

   initial begin
      assert_cnt = 0;
      fail_cnt   = 0;
      nrst       = 1'b1;
      start      = 1'b0;
      relu_en    = 1'b0;
      image_data = '0;
      coeff_data = '0;

      vecs[0] = '{0, 8'd1,   16'd256,    1'b1, 8'd64};
      vecs[1] = '{0, 8'd255, 16'd32767,  1'b1, 8'hFF};
      vecs[2] = '{0, 8'd255, 16'd32767,  1'b0, 8'h7F};
      vecs[3] = '{0, 8'd1,   16'hFF00,   1'b1, 8'h00};
      vecs[4] = '{0, 8'd1,   16'hFF00,   1'b0, 8'hC0};
      vecs[5] = '{1, 8'd0,   16'd0,      1'b1, 8'h00};
      for (int n = 0; n < 16; n++)
         diag_exp[n] = 8'(n);

      // Asynchronous reset between clock edges, checked before any edge.
      #7;
      nrst = 1'b0;
      #1;
      checkOutput("reset busy", 128'(busy), 128'(0));
      checkOutput("reset done", 128'(done), 128'(0));
      checkOutput("reset result", result, 128'(0));
      repeat (2) @(negedge clk);
      nrst = 1'b1;

      // Directed table.
      for (int v = 0; v < 6; v++) begin
         loadPattern(vecs[v].kind, vecs[v].pix, vecs[v].coef);
         exp_v = (vecs[v].kind == 1) ? diag_exp : {16{vecs[v].exp_byte}};
         runAndCheck($sformatf("vec%0d", v), vecs[v].relu, 0, exp_v);
      end

      // Start pulsed mid-run and during the DONE cycle: both ignored.
      loadPattern(0, 8'd1, 16'd256);
      runAndCheck("start_mid_run", 1'b1, 50, {16{8'd64}});
      runAndCheck("start_in_done", 1'b1, BUSY_LEN + 1, {16{8'd64}});

      // Reset at cycle 100 of a run: everything clears at once.
      @(negedge clk);
      relu_en = 1'b1;
      start   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (99) @(negedge clk);
      @(posedge clk);
      #2;
      nrst = 1'b0;
      #1;
      checkOutput("midrun_reset busy", 128'(busy), 128'(0));
      checkOutput("midrun_reset done", 128'(done), 128'(0));
      checkOutput("midrun_reset result", result, 128'(0));
      @(negedge clk);
      nrst = 1'b1;
      runAndCheck("after_reset", 1'b1, 0, {16{8'd64}});

      // Randomized runs against the reference model. Small weights keep
      // many results inside the unsaturated range.
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 64; i++)
            image_data[i] = 8'($urandom_range(0, 255));
         for (int j = 0; j < 1024; j++) begin
            if (r < 3)
               coeff_data[j] = 16'($signed($urandom_range(0, 255)) - 128);
            else
               coeff_data[j] = 16'($urandom);
         end
         exp_v = refLayer(r[0]);
         runAndCheck($sformatf("rand%0d", r), r[0], 0, exp_v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               assert_cnt, fail_cnt);
      $finish;
   end

endmodule
